// File: rtl/grey_ptr_decoder.sv
// Gray-coded pointer receiver. It synchronises a Gray count from a remote
// clock domain, decodes it to binary and classifies each movement:
//   +1 gives a step_up pulse, -1 gives a step_dn pulse, and any other jump
//   sets the sticky fault flag.
// After reset the synchroniser must refill before any value is trusted,
// so steps and faults are not evaluated while it primes.
module grey_ptr_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] grey_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             fault
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DELTA_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] DELTA_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DELTA_NEG1 = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Gray to binary conversion: each binary bit is the XOR of all Gray bits at
    // or above it.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] bin_s;
    logic [WIDTH-1:0] delta_s;
    logic             is_up_s;
    logic             is_dn_s;
    logic             is_bad_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;

    // Multi-flop synchroniser. The Gray input changes only one bit per step,
    // so each stage samples either the old code or the new code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= grey_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Decode the synchronised code and classify its distance (mod 2^WIDTH)
    // from the value currently on bin_out.
    always_comb begin
        bin_s    = g2b(sync_r[SYNC_STAGES-1]);
        delta_s  = bin_s - bin_out;
        is_up_s  = 1'b0;
        is_dn_s  = 1'b0;
        is_bad_s = 1'b0;
        if (delta_s == DELTA_ONE) begin
            is_up_s = 1'b1;
        end else if (delta_s == DELTA_NEG1) begin
            is_dn_s = 1'b1;
        end else if (delta_s != DELTA_ZERO) begin
            is_bad_s = 1'b1;
        end else begin
            is_bad_s = 1'b0;
        end
    end

    // Control FSM and registered outputs. bin_out always follows the decoder,
    // and the pulses are registered together with it so that they line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_PRIME;
            cnt_r     <= {CNT_W{1'b0}};
            bin_out   <= {WIDTH{1'b0}};
            bin_valid <= 1'b0;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            bin_out <= bin_s;
            case (state_r)
                ST_PRIME: begin
                    step_up <= 1'b0;
                    step_dn <= 1'b0;
                    fault   <= 1'b0;
                    if (cnt_r == PRIME_LAST) begin
                        state_r   <= ST_TRACK;
                        bin_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_TRACK: begin
                    step_up <= is_up_s;
                    step_dn <= is_dn_s;
                    if (is_bad_s) begin
                        fault   <= 1'b1;
                        state_r <= ST_FAULT;
                    end else begin
                        fault <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    step_up <= is_up_s;
                    step_dn <= is_dn_s;
                    // A new illegal jump takes priority over a clear request.
                    if (is_bad_s) begin
                        fault <= 1'b1;
                    end else if (err_clr) begin
                        fault   <= 1'b0;
                        state_r <= ST_TRACK;
                    end else begin
                        fault <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_PRIME;
                    cnt_r     <= {CNT_W{1'b0}};
                    bin_valid <= 1'b0;
                    step_up   <= 1'b0;
                    step_dn   <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grey_ptr_decoder.sv
// Directed bench for grey_ptr_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_grey_ptr_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] grey_in;
    logic       err_clr;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       step_up;
    logic       step_dn;
    logic       fault;

    int n_vec;
    int n_err;
    logic [3:0] prev_bin;

    // Gray codes for binary values 0..15, written out by hand.
    localparam logic [3:0] GC [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110,
        4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    grey_ptr_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .grey_in   (grey_in),
        .err_clr   (err_clr),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_up   (step_up),
        .step_dn   (step_dn),
        .fault     (fault)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Change the Gray input at a falling edge, then check the latency, the
    // new value with its pulses, and that the pulses end after one cycle.
    task automatic step_to(input logic [3:0] g, input logic [3:0] eb,
                           input logic eu, input logic ed, input logic ef,
                           input logic clr);
        grey_in = g;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("latency_hold", {28'd0, bin_out}, {28'd0, prev_bin});
        err_clr = clr;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
        check_val("bin_out", {28'd0, bin_out}, {28'd0, eb});
        check_val("step_up", {31'd0, step_up}, {31'd0, eu});
        check_val("step_dn", {31'd0, step_dn}, {31'd0, ed});
        check_val("fault", {31'd0, fault}, {31'd0, ef});
        @(posedge clk);
        @(negedge clk);
        check_val("up_one_cycle", {31'd0, step_up}, 32'd0);
        check_val("dn_one_cycle", {31'd0, step_dn}, 32'd0);
        check_val("fault_after", {31'd0, fault}, {31'd0, ef});
        prev_bin = eb;
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {24'd0, bin_out, bin_valid, step_up, step_dn, fault}, 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        prev_bin = 4'd0;
        rst_n    = 1'b0;
        grey_in  = 4'b0000;
        err_clr  = 1'b0;

        // 1. Reset state, then prime.
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("prime_not_valid", {31'd0, bin_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("prime_valid", {31'd0, bin_valid}, 32'd1);
        check_val("prime_no_pulse", {29'd0, step_up, step_dn, fault}, 32'd0);
        check_val("prime_bin", {28'd0, bin_out}, 32'd0);

        // 2. Walk upward through all codes, including the wrap from 15 to 0.
        for (int i = 1; i < 16; i++) begin
            step_to(GC[i], 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step_to(GC[0], 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3. Walk downward, including the wrap from 0 to 15.
        for (int i = 15; i >= 0; i--) begin
            step_to(GC[i], 4'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // 4. An illegal jump from 1 to 4 sets fault; fault is sticky until cleared.
        step_to(GC[1], 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step_to(4'b0110, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_val("fault_sticky", {31'd0, fault}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("fault_cleared", {31'd0, fault}, 32'd0);

        // 5. Re-enter FAULT (4 -> 1), step legally while faulted, then clear
        //    during an illegal 4 -> 9 jump: the fault must stay set.
        step_to(GC[1], 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step_to(GC[2], 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        step_to(GC[3], 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step_to(GC[4], 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        step_to(GC[9], 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("fault_cleared_late", {31'd0, fault}, 32'd0);

        // 6. Walk down to 7, then apply an asynchronous reset pulse and re-prime.
        step_to(GC[8], 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        step_to(GC[7], 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("pre_reset_valid", {31'd0, bin_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("reprime_not_valid", {31'd0, bin_valid}, 32'd0);
        check_val("reprime_bin_hold", {28'd0, bin_out}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("reprime_valid", {31'd0, bin_valid}, 32'd1);
        check_val("reprime_bin", {28'd0, bin_out}, 32'd7);
        check_val("reprime_no_pulse", {29'd0, step_up, step_dn, fault}, 32'd0);
        @(negedge clk);
        check_val("reprime_quiet", {29'd0, step_up, step_dn, fault}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
